// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the AD7324 scan sequencer.
// Holds the FSM encoding, channel IDs and control-word fields.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STORE = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [1:0] CH_VOUT = 2'd0;
    localparam logic [1:0] CH_TEMP = 2'd1;
    localparam logic [1:0] CH_VIN  = 2'd2;
    localparam logic [1:0] CH_IOUT = 2'd3;

    // Control register layout: write, reg select, pad, address, pad.
    localparam logic       CTRL_WRITE    = 1'b1;
    localparam logic [1:0] CTRL_REG_CTRL = 2'b00;
    localparam logic [1:0] CTRL_PAD_HI   = 2'b00;
    localparam logic [8:0] CTRL_PAD_LO   = 9'h000;

    // Two's complement to offset binary is a flip of the sign bit.
    function automatic logic [12:0] to_offset(input logic [12:0] d);
        return {~d[12], d[11:0]};
    endfunction

    function automatic logic [15:0] ctrl_word(input logic [1:0] ch);
        return {CTRL_WRITE, CTRL_REG_CTRL, CTRL_PAD_HI, ch, CTRL_PAD_LO};
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_pick.sv
// Round-robin channel picker: next set mask bit above the
// current ID, wrapping 3->0; returns the same ID for a one-bit mask.
module adc_rr_pick (
    input  logic [3:0] i_mask,
    input  logic [1:0] i_cur,
    output logic [1:0] o_next,
    output logic       o_none
);

    logic [1:0] w_idx;
    logic       w_found;

    // Scan the four positions after i_cur, first hit wins.
    always_comb begin
        o_next  = i_cur;
        w_found = 1'b0;
        w_idx   = i_cur;
        for (int k = 1; k <= 4; k++) begin
            w_idx = i_cur + 2'(k);
            if (!w_found && i_mask[w_idx]) begin
                o_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign o_none = ~|i_mask;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Channel scheduler for the AD7324 SPI path: round-robin frames,
// one-frame result pipeline, offset-binary per-channel registers.
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int PERIOD  = 64,
    parameter int TIMEOUT = 1024,
    parameter int RES     = 13
) (
    input  logic           CLK,
    input  logic           RSTp,
    input  logic           en,
    input  logic [3:0]     ch_mask,
    input  logic           err_clr,
    output logic           spi_start,
    output logic [15:0]    spi_ctrl,
    input  logic           spi_done,
    input  logic [15:0]    spi_data,
    output logic [RES-1:0] vout,
    output logic [RES-1:0] temp,
    output logic [RES-1:0] vin,
    output logic [RES-1:0] iout,
    output logic [3:0]     meas_valid,
    output logic           err_id,
    output logic           err_to,
    output logic           busy
);

    localparam int CMAX = (PERIOD > TIMEOUT) ? PERIOD : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_ch, w_ch_nxt;
    logic [1:0]      r_prev_ch, w_prev_nxt;
    logic [1:0]      r_exp_ch, w_exp_nxt;
    logic            r_prime, w_prime_nxt;
    logic [3:0]      r_mask, w_mask_nxt;
    logic [14:0]     r_data, w_data_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [15:0]     r_ctrl, w_ctrl_nxt;
    logic [3:0]      r_valid, w_valid_nxt;
    logic            w_wr;
    logic            w_err_id_set;
    logic            w_err_to_set;
    logic            r_err_id, r_err_to;
    logic [RES-1:0]  r_vout, r_temp, r_vin, r_iout;

    logic [1:0]      w_pick_cur;
    logic [1:0]      w_pick;
    logic            w_none;
    logic [12:0]     w_off;
    logic [RES-1:0]  w_res;
    logic            w_unused;

    // From IDLE the search starts above ID 3 so the lowest set bit wins.
    assign w_pick_cur = (r_state == ST_IDLE) ? 2'd3 : r_ch;

    adc_rr_pick u_pick (
        .i_mask (ch_mask),
        .i_cur  (w_pick_cur),
        .o_next (w_pick),
        .o_none (w_none)
    );

    assign w_off    = to_offset(r_data[12:0]);
    assign w_res    = w_off[12 -: RES];
    assign w_unused = spi_data[15];

    // Next-state and datapath control for the scan FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_prev_nxt   = r_prev_ch;
        w_exp_nxt    = r_exp_ch;
        w_prime_nxt  = r_prime;
        w_mask_nxt   = r_mask;
        w_data_nxt   = r_data;
        w_cnt_nxt    = r_cnt;
        w_ctrl_nxt   = r_ctrl;
        w_valid_nxt  = 4'b0000;
        w_wr         = 1'b0;
        w_err_id_set = 1'b0;
        w_err_to_set = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (en && !w_none) begin
                    w_state_nxt = ST_ISSUE;
                    w_ch_nxt    = w_pick;
                    w_ctrl_nxt  = ctrl_word(w_pick);
                    w_mask_nxt  = ch_mask;
                    w_prime_nxt = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_exp_nxt   = r_prev_ch;
                w_prev_nxt  = r_ch;
                w_cnt_nxt   = CW'(1);
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (spi_done) begin
                    w_data_nxt  = spi_data[14:0];
                    w_state_nxt = ST_STORE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_err_to_set = 1'b1;
                    w_prime_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STORE: begin
                if (r_prime) begin
                    w_prime_nxt = 1'b0;
                end else if (r_data[14:13] != r_exp_ch) begin
                    w_err_id_set = 1'b1;
                end else begin
                    w_wr                  = 1'b1;
                    w_valid_nxt[r_exp_ch] = 1'b1;
                end
                w_cnt_nxt   = '0;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (r_cnt == CW'(PERIOD - 1)) begin
                    if (!en || w_none) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_ch_nxt    = w_pick;
                        w_ctrl_nxt  = ctrl_word(w_pick);
                        w_mask_nxt  = ch_mask;
                        if (ch_mask != r_mask) begin
                            w_prime_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM and sequencing registers.
    always_ff @(posedge CLK or posedge RSTp) begin
        if (RSTp) begin
            r_state   <= ST_IDLE;
            r_ch      <= 2'd0;
            r_prev_ch <= 2'd0;
            r_exp_ch  <= 2'd0;
            r_prime   <= 1'b1;
            r_mask    <= 4'd0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_ctrl    <= 16'h8000;
            r_valid   <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_prev_ch <= w_prev_nxt;
            r_exp_ch  <= w_exp_nxt;
            r_prime   <= w_prime_nxt;
            r_mask    <= w_mask_nxt;
            r_data    <= w_data_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    // Per-channel result registers, written from STORE.
    always_ff @(posedge CLK or posedge RSTp) begin
        if (RSTp) begin
            r_vout <= '0;
            r_temp <= '0;
            r_vin  <= '0;
            r_iout <= '0;
        end else if (w_wr) begin
            unique case (r_exp_ch)
                CH_VOUT: r_vout <= w_res;
                CH_TEMP: r_temp <= w_res;
                CH_VIN:  r_vin  <= w_res;
                CH_IOUT: r_iout <= w_res;
                default: r_vout <= w_res;
            endcase
        end
    end

    // Sticky error flags; a new error beats a coincident clear.
    always_ff @(posedge CLK or posedge RSTp) begin
        if (RSTp) begin
            r_err_id <= 1'b0;
            r_err_to <= 1'b0;
        end else begin
            if (w_err_id_set) begin
                r_err_id <= 1'b1;
            end else if (err_clr) begin
                r_err_id <= 1'b0;
            end
            if (w_err_to_set) begin
                r_err_to <= 1'b1;
            end else if (err_clr) begin
                r_err_to <= 1'b0;
            end
        end
    end

    assign spi_start  = (r_state == ST_ISSUE);
    assign spi_ctrl   = r_ctrl;
    assign busy       = (r_state != ST_IDLE);
    assign meas_valid = r_valid;
    assign err_id     = r_err_id;
    assign err_to     = r_err_to;
    assign vout       = r_vout;
    assign temp       = r_temp;
    assign vin        = r_vin;
    assign iout       = r_iout;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with an AD7324 frame model.
// Two instances (RES=13 and RES=8) run in lockstep on shared inputs.
module tb_adc_scan_sequencer;

    localparam int PER = 4;
    localparam int TMO = 20;
    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        RSTp = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  ch_mask = 4'd0;
    logic        err_clr = 1'b0;
    logic        spi_done;
    logic [15:0] spi_data;

    logic        a_start, a_err_id, a_err_to, a_busy;
    logic [15:0] a_ctrl;
    logic [12:0] a_vout, a_temp, a_vin, a_iout;
    logic [3:0]  a_valid;

    logic        b_start, b_err_id, b_err_to, b_busy;
    logic [15:0] b_ctrl;
    logic [7:0]  b_vout, b_temp, b_vin, b_iout;
    logic [3:0]  b_valid;

    int total = 0;
    int bad = 0;

    logic [12:0] m_data [4];
    logic        m_mute = 1'b0;
    logic        m_bad = 1'b0;
    int          m_cnt;
    logic [1:0]  m_last, m_resp, m_id;

    adc_scan_sequencer #(.PERIOD(PER), .TIMEOUT(TMO), .RES(13)) dut_a (
        .CLK(CLK), .RSTp(RSTp), .en(en), .ch_mask(ch_mask),
        .err_clr(err_clr), .spi_start(a_start), .spi_ctrl(a_ctrl),
        .spi_done(spi_done), .spi_data(spi_data),
        .vout(a_vout), .temp(a_temp), .vin(a_vin), .iout(a_iout),
        .meas_valid(a_valid), .err_id(a_err_id), .err_to(a_err_to),
        .busy(a_busy)
    );

    adc_scan_sequencer #(.PERIOD(PER), .TIMEOUT(TMO), .RES(8)) dut_b (
        .CLK(CLK), .RSTp(RSTp), .en(en), .ch_mask(ch_mask),
        .err_clr(err_clr), .spi_start(b_start), .spi_ctrl(b_ctrl),
        .spi_done(spi_done), .spi_data(spi_data),
        .vout(b_vout), .temp(b_temp), .vin(b_vin), .iout(b_iout),
        .meas_valid(b_valid), .err_id(b_err_id), .err_to(b_err_to),
        .busy(b_busy)
    );

    always #25 CLK = ~CLK;

    // ADC model: returns the ID/data of the previous request after LAT cycles.
    initial begin
        spi_done = 1'b0;
        spi_data = 16'd0;
        m_cnt    = 0;
        m_last   = 2'd0;
        m_resp   = 2'd0;
        m_id     = 2'd0;
        forever begin
            @(negedge CLK);
            spi_done = 1'b0;
            if (RSTp) begin
                m_cnt = 0;
            end else if (a_start) begin
                m_resp = m_last;
                m_last = a_ctrl[10:9];
                m_cnt  = LAT;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0 && !m_mute) begin
                    m_id = m_bad ? (m_resp ^ 2'b01) : m_resp;
                    m_bad = 1'b0;
                    spi_data = {1'b0, m_id, m_data[m_resp]};
                    spi_done = 1'b1;
                end
            end
        end
    end

    function automatic logic [12:0] a_reg(input int ch);
        case (ch)
            0: return a_vout;
            1: return a_temp;
            2: return a_vin;
            default: return a_iout;
        endcase
    endfunction

    function automatic logic [7:0] b_reg(input int ch);
        case (ch)
            0: return b_vout;
            1: return b_temp;
            2: return b_vin;
            default: return b_iout;
        endcase
    endfunction

    task automatic wait_start(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge CLK);
            if (a_start) ok = 1'b1;
        end
    endtask

    task automatic wait_strobe(input int maxc, output logic [3:0] v,
                               output int n);
        v = 4'd0;
        n = 0;
        for (int i = 0; i < maxc && v == 4'd0; i++) begin
            @(negedge CLK);
            n = i + 1;
            v = a_valid;
        end
    endtask

    task automatic wait_idle(input int maxc, output bit ok,
                             output int starts);
        ok = 1'b0;
        starts = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge CLK);
            if (a_start) starts++;
            if (!a_busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        RSTp = 1'b1;
        en = 1'b0;
        ch_mask = 4'd0;
        repeat (3) @(negedge CLK);
        total++;
        if (a_busy !== 1'b0 || a_start !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy_start got=%b%b want=00", a_busy, a_start);
        end
        total++;
        if (a_ctrl !== 16'h8000) begin
            bad++;
            $display("FAIL rst_ctrl got=%h want=8000", a_ctrl);
        end
        total++;
        if ({a_valid, a_err_id, a_err_to} !== 6'd0) begin
            bad++;
            $display("FAIL rst_flags got=%b want=0", {a_valid, a_err_id, a_err_to});
        end
        total++;
        if ({a_vout, a_temp, a_vin, a_iout, b_vout} !== 60'd0) begin
            bad++;
            $display("FAIL rst_regs got=%h want=0", {a_vout, a_temp, a_vin, a_iout, b_vout});
        end
        RSTp = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_en got=%b want=0", a_busy);
        end
    endtask

    task automatic test_scan_all;
        bit ok;
        logic [3:0] v;
        int n, st;
        logic [15:0] ec;
        for (int c = 0; c < 4; c++) m_data[c] = 13'h1FFF;
        ch_mask = 4'hF;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_start(30, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL all_start%0d got=none want=start", i);
            end
            ec = 16'h8000 | (16'(i % 4) << 9);
            total++;
            if (a_ctrl !== ec) begin
                bad++;
                $display("FAIL all_ctrl%0d got=%h want=%h", i, a_ctrl, ec);
            end
            if (i == 0) begin
                wait_strobe(7, v, n);
                total++;
                if (v !== 4'd0) begin
                    bad++;
                    $display("FAIL all_prime got=%b want=0000", v);
                end
            end else begin
                st = (i - 1) % 4;
                wait_strobe(8, v, n);
                total++;
                if (v !== (4'b0001 << st)) begin
                    bad++;
                    $display("FAIL all_valid%0d got=%b want=%b", i, v, 4'b0001 << st);
                end
                total++;
                if (a_reg(st) !== 13'h0FFF || b_reg(st) !== 8'h7F) begin
                    bad++;
                    $display("FAIL all_reg%0d got=%h/%h want=0fff/7f", i, a_reg(st), b_reg(st));
                end
                if (i == 1) begin
                    total++;
                    if (n !== LAT + 2) begin
                        bad++;
                        $display("FAIL all_latency got=%0d want=%0d", n, LAT + 2);
                    end
                end
            end
        end
        en = 1'b0;
        wait_idle(30, ok, n);
        total++;
        if (!ok || n != 0) begin
            bad++;
            $display("FAIL all_stop got=ok%0d/starts%0d want=ok1/starts0", ok, n);
        end
    endtask

    task automatic test_two_ch;
        bit ok;
        logic [3:0] v;
        int n, rq, st;
        m_data[0] = 13'h1000;
        m_data[2] = 13'h0FFF;
        ch_mask = 4'b0101;
        en = 1'b1;
        @(negedge CLK);
        total++;
        if (a_start !== 1'b1 || a_ctrl !== 16'h8000) begin
            bad++;
            $display("FAIL two_first got=%b/%h want=1/8000", a_start, a_ctrl);
        end
        wait_strobe(7, v, n);
        for (int i = 1; i < 4; i++) begin
            rq = (i % 2 == 1) ? 2 : 0;
            st = 2 - rq;
            wait_start(30, ok);
            total++;
            if (!ok || a_ctrl !== (16'h8000 | (16'(rq) << 9))) begin
                bad++;
                $display("FAIL two_ctrl%0d got=%h want=ch%0d", i, a_ctrl, rq);
            end
            wait_strobe(8, v, n);
            total++;
            if (v !== (4'b0001 << st)) begin
                bad++;
                $display("FAIL two_valid%0d got=%b want=%b", i, v, 4'b0001 << st);
            end
            total++;
            if (st == 0 && (a_vout !== 13'h0000 || b_vout !== 8'h00)) begin
                bad++;
                $display("FAIL two_vout got=%h/%h want=0000/00", a_vout, b_vout);
            end else if (st == 2 && (a_vin !== 13'h1FFF || b_vin !== 8'hFF)) begin
                bad++;
                $display("FAIL two_vin got=%h/%h want=1fff/ff", a_vin, b_vin);
            end
        end
        total++;
        if (a_temp !== 13'h0FFF) begin
            bad++;
            $display("FAIL two_temp_kept got=%h want=0fff", a_temp);
        end
        en = 1'b0;
        wait_idle(30, ok, n);
    endtask

    task automatic test_bad_id;
        bit ok;
        logic [3:0] v;
        int n;
        for (int c = 0; c < 4; c++) m_data[c] = 13'h0123;
        ch_mask = 4'hF;
        en = 1'b1;
        wait_start(30, ok);
        wait_strobe(7, v, n);
        wait_start(30, ok);
        wait_strobe(8, v, n);
        total++;
        if (v !== 4'b0001 || a_vout !== 13'h1123) begin
            bad++;
            $display("FAIL id_vout got=%b/%h want=0001/1123", v, a_vout);
        end
        wait_start(30, ok);
        m_bad = 1'b1;
        wait_strobe(7, v, n);
        total++;
        if (v !== 4'd0 || a_err_id !== 1'b1) begin
            bad++;
            $display("FAIL id_err got=%b/%b want=0000/1", v, a_err_id);
        end
        total++;
        if (a_temp !== 13'h0FFF) begin
            bad++;
            $display("FAIL id_temp_kept got=%h want=0fff", a_temp);
        end
        wait_start(30, ok);
        wait_strobe(8, v, n);
        total++;
        if (v !== 4'b0100 || a_vin !== 13'h1123 || b_vin !== 8'h89) begin
            bad++;
            $display("FAIL id_vin got=%b/%h/%h want=0100/1123/89", v, a_vin, b_vin);
        end
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        total++;
        if (a_err_id !== 1'b0) begin
            bad++;
            $display("FAIL id_clr got=%b want=0", a_err_id);
        end
        en = 1'b0;
        wait_idle(30, ok, n);
    endtask

    task automatic test_timeout;
        bit ok;
        logic [3:0] v;
        int n;
        m_data[0] = 13'h0AAA;
        ch_mask = 4'b0001;
        en = 1'b1;
        wait_start(30, ok);
        wait_strobe(7, v, n);
        wait_start(30, ok);
        wait_strobe(8, v, n);
        total++;
        if (v !== 4'b0001 || a_vout !== 13'h1AAA || a_err_to !== 1'b0) begin
            bad++;
            $display("FAIL to_pre got=%b/%h/%b want=0001/1aaa/0", v, a_vout, a_err_to);
        end
        wait_start(30, ok);
        m_mute = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * TMO && !a_err_to; i++) begin
            @(negedge CLK);
            n = i + 1;
        end
        m_mute = 1'b0;
        m_data[0] = 13'h0555;
        total++;
        if (n != TMO || a_err_to !== 1'b1) begin
            bad++;
            $display("FAIL to_cycles got=%0d want=%0d", n, TMO);
        end
        wait_start(40, ok);
        wait_strobe(7, v, n);
        total++;
        if (!ok || v !== 4'd0) begin
            bad++;
            $display("FAIL to_prime got=%b want=0000", v);
        end
        wait_start(30, ok);
        wait_strobe(8, v, n);
        total++;
        if (v !== 4'b0001 || a_vout !== 13'h1555) begin
            bad++;
            $display("FAIL to_after got=%b/%h want=0001/1555", v, a_vout);
        end
        en = 1'b0;
        wait_idle(30, ok, n);
    endtask

    task automatic test_en_drop;
        bit ok;
        logic [3:0] v;
        int n, s;
        m_data[0] = 13'h0001;
        ch_mask = 4'b0001;
        en = 1'b1;
        wait_start(30, ok);
        wait_strobe(7, v, n);
        wait_start(30, ok);
        @(negedge CLK);
        en = 1'b0;
        total++;
        if (a_busy !== 1'b1) begin
            bad++;
            $display("FAIL drop_busy got=%b want=1", a_busy);
        end
        wait_strobe(8, v, n);
        total++;
        if (v !== 4'b0001 || n != 4 || a_vout !== 13'h1001) begin
            bad++;
            $display("FAIL drop_store got=%b/%0d/%h want=0001/4/1001", v, n, a_vout);
        end
        wait_idle(20, ok, n);
        s = n;
        repeat (10) begin
            @(negedge CLK);
            if (a_start) s++;
        end
        total++;
        if (!ok || s != 0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_idle got=ok%0d/starts%0d want=ok1/starts0", ok, s);
        end
        total++;
        if (a_err_to !== 1'b1) begin
            bad++;
            $display("FAIL err_to_sticky got=%b want=1", a_err_to);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [3:0] v;
        int n;
        for (int c = 0; c < 4; c++) m_data[c] = 13'h1ABC;
        ch_mask = 4'hF;
        en = 1'b1;
        wait_start(30, ok);
        wait_start(30, ok);
        total++;
        if (a_ctrl !== 16'h8200) begin
            bad++;
            $display("FAIL mid_ctrl got=%h want=8200", a_ctrl);
        end
        @(negedge CLK);
        RSTp = 1'b1;
        #1;
        total++;
        if (a_busy !== 1'b0 || a_start !== 1'b0 || a_ctrl !== 16'h8000) begin
            bad++;
            $display("FAIL mid_rst_ctl got=%b/%b/%h want=0/0/8000", a_busy, a_start, a_ctrl);
        end
        total++;
        if ({a_valid, a_err_id, a_err_to} !== 6'd0 ||
            {a_vout, a_temp, a_vin, a_iout, b_vout} !== 60'd0) begin
            bad++;
            $display("FAIL mid_rst_regs got=%b/%h want=0/0", {a_valid, a_err_id, a_err_to}, a_vout);
        end
        repeat (2) @(negedge CLK);
        RSTp = 1'b0;
        wait_start(10, ok);
        wait_strobe(7, v, n);
        total++;
        if (!ok || a_ctrl !== 16'h8000 || v !== 4'd0) begin
            bad++;
            $display("FAIL mid_prime got=%h/%b want=8000/0000", a_ctrl, v);
        end
        wait_start(30, ok);
        wait_strobe(8, v, n);
        total++;
        if (v !== 4'b0001 || a_vout !== 13'h0ABC) begin
            bad++;
            $display("FAIL mid_rescan got=%b/%h want=0001/0abc", v, a_vout);
        end
        en = 1'b0;
        wait_idle(30, ok, n);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) m_data[c] = 13'd0;
        test_reset();
        test_scan_all();
        test_two_ch();
        test_bad_id();
        test_timeout();
        test_en_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Channel scheduler for the AD7324 SPI ADC path. Sits between the SPI frame engine (`spi_ad7324`) and the converter control loop. Round-robins over an enabled set of the four measurement channels (Vout, Temp, Vin, Iout) and issues one 16-bit frame per slot. Accounts for the ADC's one-frame result pipeline, converts two's-complement results to offset binary, and presents per-channel registers with valid strobes and error flags.

## Interface
- `PERIOD`, default 64: idle CLK cycles between end of one frame and start of the next (≥1).
- `TIMEOUT`, default 1024: CLK cycles allowed from `spi_start` to `spi_done` before abort.
- `RES`, default 13: output width; the top `RES` bits of the 13-bit offset-binary result (1..13).
- `CLK` in 1: system clock, 20 MHz PLL domain.
- `RSTp` in 1: reset, asynchronous, active-high.
- `en` in 1: scan enable.
- `ch_mask` in 4: enabled channels; bit0 Vout, bit1 Temp, bit2 Vin, bit3 Iout.
- `err_clr` in 1: one-cycle pulse; clears sticky error flags.
- `spi_start` out 1: one-cycle pulse; frame-engine start (HOLD).
- `spi_ctrl` out 16: control word shifted on D_IN during the frame.
- `spi_done` in 1: one-cycle pulse; frame complete, `spi_data` valid this cycle.
- `spi_data` in 16: returned frame: [15] zero, [14:13] channel ID, [12:0] two's-complement result.
- `vout`, `temp`, `vin`, `iout` out RES: latest offset-binary result per channel.
- `meas_valid` out 4: one-cycle strobe per channel on register update.
- `err_id` out 1: sticky; returned ID ≠ expected.
- `err_to` out 1: sticky; frame timeout.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, STORE, GAP.
- IDLE: when `en`=1 and `ch_mask`≠0, pick the lowest set mask bit → ISSUE; set `prime`=1 (next returned data is a dummy).
- ISSUE, one cycle: drive `spi_ctrl` = {1'b1, 2'b00, CTRL_PAD_HI, ch[1:0], CTRL_PAD_LO}; pulse `spi_start`; set `exp_ch`←`prev_ch`, `prev_ch`←`ch` → WAIT. `spi_ctrl` is held stable until the next ISSUE.
- WAIT: on `spi_done` → STORE, latching `spi_data`. If the timeout counter reaches `TIMEOUT` first: set `err_to`, set `prime`=1 → GAP.
- STORE, one cycle:
  - If `prime`, discard and clear `prime`.
  - Else if `spi_data[14:13]`≠`exp_ch`, set `err_id` and discard.
  - Else write `{~d[12], d[11:0]}[12:13-RES]` to the register selected by `exp_ch` and pulse its `meas_valid` bit.
  - Then → GAP.
- GAP: count `PERIOD` cycles. At expiry, resample `en` and `ch_mask`:
  - `en`=0 or mask=0 → IDLE.
  - Otherwise take the next channel = next set mask bit above `ch`, wrapping 3→0 → ISSUE.
  - If the mask changed since the last slot, set `prime`=1.
- `en` deassert mid-frame: the current frame completes (STORE or timeout), then IDLE at GAP expiry. No frame is truncated.
- `spi_done` outside WAIT is ignored.
- `err_clr` coincident with a new error: the error wins (flag stays set).
- Single-bit mask: the same channel every slot; after the prime frame every frame stores.

## Timing
- Reset values: all data registers 0, `meas_valid`=0, `spi_start`=0, `spi_ctrl`=16'h8000, `err_id`=`err_to`=0, `busy`=0, state IDLE, `prime`=1, `ch`=`prev_ch`=0.
- Reset asserted mid-frame: immediate return to reset values. The frame engine is reset by the same `RSTp`.
- `en`&mask seen in IDLE → `spi_start` on the next cycle.
- `spi_done` at cycle t → register and `meas_valid` update at edge t+2 (STORE registers).
- Slot length = 1 (ISSUE) + frame latency + 1 (STORE) + `PERIOD`.
- Result latency: a channel requested in slot k appears after slot k+1's frame.

## Structure
- Package `adc_seq_pkg`:
  - state enum
  - channel IDs CH_VOUT=0, CH_TEMP=1, CH_VIN=2, CH_IOUT=3
  - control-word field constants CTRL_WRITE, CTRL_REG_CTRL, CTRL_PAD_HI, CTRL_PAD_LO
  - offset conversion function
- One sub-module `adc_rr_pick`: combinational next-set-bit-with-wrap over a 4-bit mask. Inputs: mask, current ID. Outputs: next ID, none flag.

## Test plan
- Mask 4'b1111, `PERIOD`=4; model returns ID of the previous request with data 13'h1FFF (−1):
  - first frame discarded
  - then `vout`=13'h0FFF with `meas_valid`=0001
  - then temp, vin, iout in order, wrapping to vout.
- Mask 4'b0101: ISSUE channels follow 0,2,0,2. Data 13'h1000 (−4096) → register 0; 13'h0FFF → 13'h1FFF. `RES`=8 gives the top 8 bits.
- Model returns the wrong ID once: `err_id`=1, no strobe, other channels unaffected. `err_clr` → 0.
- Model never asserts `spi_done`: `err_to` set at exactly `TIMEOUT` cycles. The next frame is primed (discarded), and the one after it stores.
- `en` dropped during WAIT: the frame completes and stores, then `busy`=0 after GAP with no further `spi_start`.
- `RSTp` pulsed during WAIT: all outputs at reset values in the same cycle. Rescan begins with a prime frame.
